rf_multiport: RTL and testbench

//  Parametrised register file for the pipelined CPU: NUM_RD read ports, one write port, register 0 hardwired to zero.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_read_port.sv | 50 +++++
 rtl/rf_multiport.sv | 132 +++++++++++++
 tb/tb_rf_multiport.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file: default geometry and
// the encoding of the halt-triggered dump state machine.
package rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: zero-register override, write-to-read bypass and
// an output flop that holds its value while the port is not enabled.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // wr_en already excludes the suppressed register-0 write, so a bypass
  // never forwards data that will not actually be stored.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) begin
      if ((ZERO_R0 != 0) && (addr == '0)) begin
        rd_data_d = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rf_multiport.sv
// Register file with NUM_RD synchronous read ports, one write port and a
// halt-triggered sequential dump of the register contents.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     hlt,
  output logic                     dump_vld,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = (ZERO_R0 != 0) ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  assign wr_en = we && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] port_addr;
    assign port_addr = rd_addr[gi*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_R0 (ZERO_R0)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .re       (re[gi]),
      .addr     (port_addr),
      .mem_word (mem_q[port_addr]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[gi*DATA_W +: DATA_W])
    );
  end

  dump_state_e       state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              hlt_q;
  logic              dump_vld_q;
  logic              dump_done_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;

  // Dump reads mem_q directly: a beat shows the value before any write
  // landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      hlt_q       <= 1'b0;
      dump_vld_q  <= 1'b0;
      dump_done_q <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      hlt_q       <= hlt;
      dump_vld_q  <= 1'b0;
      dump_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hlt && !hlt_q) begin
            state_q <= ST_DUMP;
            idx_q   <= IDX_FIRST;
          end
        end
        ST_DUMP: begin
          dump_vld_q  <= 1'b1;
          dump_addr_q <= idx_q[ADDR_W-1:0];
          dump_data_q <= mem_q[idx_q[ADDR_W-1:0]];
          idx_q       <= idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          dump_done_q <= 1'b1;
          if (!hlt) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dump_vld  = dump_vld_q;
  assign dump_addr = dump_addr_q;
  assign dump_data = dump_data_q;
  assign dump_done = dump_done_q;

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: the driver queues expected responses,
// a monitor a little after each rising edge pops and compares them.
module tb_rf_multiport;

  logic        clk;
  logic        rst, rst_a;
  logic [1:0]  re;
  logic [7:0]  rd_addr;
  logic [31:0] dut_rd_data;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        hlt, hlt_a;
  logic        dut_dump_vld, dut_dump_done;
  logic [3:0]  dut_dump_addr;
  logic [15:0] dut_dump_data;
  logic [2:0]  re_a;
  logic [11:0] rd_addr_a;
  logic [47:0] alt_rd_data;
  logic        alt_dump_vld, alt_dump_done;
  logic [3:0]  alt_dump_addr;
  logic [15:0] alt_dump_data;

  rf_multiport #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .BYPASS(1), .ZERO_R0(1)) u_dut (
    .clk(clk), .rst(rst), .re(re), .rd_addr(rd_addr), .rd_data(dut_rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt),
    .dump_vld(dut_dump_vld), .dump_addr(dut_dump_addr), .dump_data(dut_dump_data),
    .dump_done(dut_dump_done)
  );

  rf_multiport #(.DATA_W(16), .ADDR_W(4), .NUM_RD(3), .BYPASS(0), .ZERO_R0(1)) u_alt (
    .clk(clk), .rst(rst_a), .re(re_a), .rd_addr(rd_addr_a), .rd_data(alt_rd_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .hlt(hlt_a),
    .dump_vld(alt_dump_vld), .dump_addr(alt_dump_addr), .dump_data(alt_dump_data),
    .dump_done(alt_dump_done)
  );

  typedef struct {
    int          tag;
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  typedef struct {
    int          tag;
    logic [3:0]  addr;
    logic [15:0] data;
  } beat_t;

  chk_t  chk_q[$];
  beat_t beat_q[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_bad = 0;
  bit    mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end else begin
      $display("  ok %s: %h (cycle %0d)", name, got, cyc);
    end
  endtask

  function automatic logic [15:0] obs(input int kind);
    case (kind)
      0:       return dut_rd_data[15:0];
      1:       return dut_rd_data[31:16];
      2:       return alt_rd_data[15:0];
      3:       return alt_rd_data[31:16];
      4:       return alt_rd_data[47:32];
      5:       return {15'b0, dut_dump_done};
      6:       return {15'b0, dut_dump_vld};
      default: return 16'hxxxx;
    endcase
  endfunction

  // Response is due after the next rising edge.
  task automatic expect_at(input int kind, input logic [15:0] exp, input string name);
    chk_q.push_back('{cyc + 1, kind, exp, name});
  endtask

  task automatic tick();
    @(negedge clk);
    we   = 1'b0;
    re   = 2'b00;
    re_a = 3'b000;
  endtask

  // Monitor
  chk_t  c;
  beat_t b;
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      while (chk_q.size() > 0 && chk_q[0].tag <= cyc) begin
        c = chk_q.pop_front();
        check(c.name, obs(c.kind), c.exp);
      end
      if (dut_dump_vld) begin
        if (beat_q.size() == 0) begin
          check("dump unexpected beat", {15'b0, dut_dump_vld}, 16'h0);
        end else begin
          b = beat_q.pop_front();
          check($sformatf("dump beat r%0d cycle", b.addr), 16'(cyc), 16'(b.tag));
          check($sformatf("dump beat r%0d addr", b.addr), {12'b0, dut_dump_addr}, {12'b0, b.addr});
          check($sformatf("dump beat r%0d data", b.addr), dut_dump_data, b.data);
        end
      end else if (beat_q.size() > 0 && beat_q[0].tag <= cyc) begin
        b = beat_q.pop_front();
        check($sformatf("dump beat r%0d missing vld", b.addr), {15'b0, dut_dump_vld}, 16'h1);
      end
    end
  end

  int c0;

  initial begin
    rst = 1'b0; rst_a = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    re = '0; rd_addr = '0; re_a = '0; rd_addr_a = '0; hlt = 1'b0; hlt_a = 1'b0;

    // Asynchronous reset pulse between clock edges
    #12 rst = 1'b1; rst_a = 1'b1;
    #1  rst = 1'b0; rst_a = 1'b0;
    check("reset rd_data0", dut_rd_data[15:0], 16'h0000);
    check("reset rd_data1", dut_rd_data[31:16], 16'h0000);
    check("reset dump_vld", {15'b0, dut_dump_vld}, 16'h0);
    check("reset dump_done", {15'b0, dut_dump_done}, 16'h0);
    check("reset alt dump_done", {15'b0, alt_dump_done}, 16'h0);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick();
      re      = 2'b11;
      rd_addr = {4'(15 - i), 4'(i)};
      expect_at(0, 16'h0000, $sformatf("reset read p0 r%0d", i));
      expect_at(1, 16'h0000, $sformatf("reset read p1 r%0d", 15 - i));
    end

    // Same-cycle write and read of r5
    tick();
    we = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    re = 2'b11; rd_addr = {4'd6, 4'd5};
    re_a = 3'b001; rd_addr_a = {4'd0, 4'd0, 4'd5};
    expect_at(0, 16'hBEEF, "bypass r5 p0");
    expect_at(1, 16'h0000, "no-hit r6 p1");
    expect_at(2, 16'h0000, "alt no-bypass r5 old");
    tick();
    re_a = 3'b001; rd_addr_a = {4'd0, 4'd0, 4'd5};
    expect_at(2, 16'hBEEF, "alt r5 after write");
    expect_at(0, 16'hBEEF, "p0 hold with re=0");

    // Register 0 ignores writes and reads as zero even with bypass
    tick();
    we = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    re = 2'b01; rd_addr = {4'd0, 4'd0};
    expect_at(0, 16'h0000, "r0 read during write");
    expect_at(1, 16'h0000, "p1 hold");
    tick();
    re = 2'b11; rd_addr = {4'd5, 4'd0};
    expect_at(0, 16'h0000, "r0 after write");
    expect_at(1, 16'hBEEF, "r5 unchanged");

    for (int i = 1; i < 16; i++) begin
      tick();
      we = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
    end

    // Dump: r3 written while index=2 (new value seen), r4 while index=4 (old value seen)
    tick();
    hlt = 1'b1;
    c0  = cyc;
    for (int j = 1; j < 16; j++) begin
      beat_q.push_back('{c0 + 1 + j, 4'(j), (j == 3) ? 16'h0033 : 16'h1000 + 16'(j)});
    end
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 2) begin we = 1'b1; wr_addr = 4'd3; wr_data = 16'h0033; end
      if (k == 4) begin we = 1'b1; wr_addr = 4'd4; wr_data = 16'h0044; end
      if (k == 5) begin
        re = 2'b01; rd_addr = {4'd0, 4'd3};
        expect_at(0, 16'h0033, "read r3 during dump");
      end
      if (k == 16) expect_at(6, 16'h0, "dump_vld low after last beat");
      if (k >= 16 && k <= 20) expect_at(5, (k == 20) ? 16'h0 : 16'h1, $sformatf("dump_done k%0d", k));
      if (k == 19) hlt = 1'b0;
    end

    tick();
    re = 2'b11; rd_addr = {4'd4, 4'd3};
    expect_at(0, 16'h0033, "r3 after dump");
    expect_at(1, 16'h0044, "r4 after dump");
    tick();
    re = 2'b11; rd_addr = {4'd15, 4'd1};
    expect_at(0, 16'h1001, "r1");
    expect_at(1, 16'h100F, "r15");

    // Three-port instance: per-port enables
    tick();
    re_a = 3'b111; rd_addr_a = {4'd3, 4'd2, 4'd1};
    expect_at(2, 16'h1001, "alt p0 r1");
    expect_at(3, 16'h1002, "alt p1 r2");
    expect_at(4, 16'h0033, "alt p2 r3");
    tick();
    re_a = 3'b010; rd_addr_a = {4'd6, 4'd4, 4'd5};
    expect_at(2, 16'h1001, "alt p0 hold");
    expect_at(3, 16'h0044, "alt p1 r4");
    expect_at(4, 16'h0033, "alt p2 hold");

    // Reset in the middle of an alt dump
    tick();
    hlt_a = 1'b1;
    repeat (3) tick();
    check("alt dump_vld mid-dump", {15'b0, alt_dump_vld}, 16'h1);
    check("alt dump_addr mid-dump", {12'b0, alt_dump_addr}, 16'h0002);
    check("alt dump_data mid-dump", alt_dump_data, 16'h1002);
    #1 rst_a = 1'b1;
    #1;
    check("alt dump_vld on reset", {15'b0, alt_dump_vld}, 16'h0);
    check("alt p1 on reset", alt_rd_data[31:16], 16'h0000);
    hlt_a = 1'b0;
    rst_a = 1'b0;
    tick();
    re_a = 3'b001; rd_addr_a = {4'd0, 4'd0, 4'd4};
    re = 2'b01; rd_addr = {4'd0, 4'd4};
    expect_at(2, 16'h0000, "alt r4 cleared");
    expect_at(0, 16'h0044, "main r4 untouched");

    repeat (3) tick();
    check("pending checks drained", 16'(chk_q.size()), 16'h0);
    check("pending beats drained", 16'(beat_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
